// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
//   Link between the fetch stage (IF/ID producer) and the decode stage /
//   hazard unit.
//
//   Hazard / redirect controls (driven by decode side):
//     StallF, StallD, FlushD  - hazard-unit stall and flush requests
//     PCSrcD, PCTargetD       - branch/jump redirect resolved in decode
//   IF/ID contents (driven by fetch side):
//     InstrD, PCPlus4D        - instruction and its PC+4 for decode
//     InstrValidD             - InstrD holds a real fetched instruction
//     cnt                     - saturating cycles-since-reset counter
//
//   master : fetch stage      slave : decode stage / hazard unit
// ---------------------------------------------------------------------------
interface fetch_stage_if;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcD;
  logic [31:0] PCTargetD;
  logic [31:0] InstrD;
  logic [31:0] PCPlus4D;
  logic        InstrValidD;
  logic [3:0]  cnt;

  modport master (
    input  StallF, StallD, FlushD, PCSrcD, PCTargetD,
    output InstrD, PCPlus4D, InstrValidD, cnt
  );

  modport slave (
    output StallF, StallD, FlushD, PCSrcD, PCTargetD,
    input  InstrD, PCPlus4D, InstrValidD, cnt
  );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage plus IF/ID pipeline register of the MIPS
//   pipeline. Holds the PC, addresses the instruction memory, applies
//   hazard-unit stalls/flushes and decode-resolved redirects, and keeps a
//   saturating warm-up counter that decode uses to ignore InstrD right
//   after reset.
//
//   Ports:
//     clk        - system clock, rising edge
//     rst        - asynchronous, active-high reset
//     ImemAddrF  - word address to instruction memory (PCF[IMEM_AW+1:2])
//     ImemDataF  - instruction word returned combinationally for ImemAddrF
//     PCF        - current fetch PC
//     dec        - fetch_stage_if.master: hazard/redirect inputs and the
//                  IF/ID outputs (InstrD, PCPlus4D, InstrValidD, cnt)
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,  // bits [1:0] must be 0
  parameter int          IMEM_AW  = 8,
  parameter logic [3:0]  CNT_MAX  = 4'd15
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] ImemAddrF,
  input  logic [31:0]        ImemDataF,
  output logic [31:0]        PCF,
  fetch_stage_if.master      dec
);

  logic [31:0] pcReg;
  logic [31:0] pcPlus4F;
  logic [31:0] pcNext;
  logic [31:0] instrReg;
  logic [31:0] pcPlus4Reg;
  logic        validReg;
  logic [3:0]  cntReg;

  // Wraps modulo 2^32, so 32'hFFFF_FFFC steps to 0.
  assign pcPlus4F  = pcReg + 32'd4;
  assign PCF       = pcReg;
  assign ImemAddrF = pcReg[IMEM_AW+1:2];

  // Stall beats redirect: the hazard unit holds PCSrcD high until the stall
  // releases, so a redirect seen under StallF is not lost. Redirect targets
  // are forced word-aligned.
  // NOTE: every combinational output gets a default first so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    pcNext = pcPlus4F;
    if (dec.StallF)      pcNext = pcReg;
    else if (dec.PCSrcD) pcNext = dec.PCTargetD & 32'hFFFF_FFFC;
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others; blocking here would create order-dependent
  // simulation that no longer matches the synthesized flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcReg <= RESET_PC;
    end else begin
      pcReg <= pcNext;
    end
  end

  // IF/ID register. Flush wins over stall so a squashed slot never survives
  // a simultaneous stall. A redirect alone does not flush: the delay-slot
  // instruction proceeds unless the hazard unit also raises FlushD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instrReg   <= 32'd0;
      pcPlus4Reg <= 32'd0;
      validReg   <= 1'b0;
    end else if (dec.FlushD) begin
      instrReg   <= 32'd0;
      pcPlus4Reg <= 32'd0;
      validReg   <= 1'b0;
    end else if (!dec.StallD) begin
      instrReg   <= ImemDataF;
      pcPlus4Reg <= pcPlus4F;
      validReg   <= 1'b1;
    end
  end

  // Warm-up counter: counts every edge regardless of stalls/flushes and
  // sticks at CNT_MAX so it can never wrap back into the "ignore" window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntReg <= 4'd0;
    end else if (cntReg != CNT_MAX) begin
      cntReg <= cntReg + 4'd1;
    end
  end

  assign dec.InstrD      = instrReg;
  assign dec.PCPlus4D    = pcPlus4Reg;
  assign dec.InstrValidD = validReg;
  assign dec.cnt         = cntReg;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Two instances: dutA with RESET_PC=0 (main scenarios) and dutB with
//   RESET_PC=FFFF_FFF8 (PC wrap and counter saturation). Stimulus pushes the
//   hand-computed post-edge state into a per-DUT queue; a monitor on the
//   falling edge pops and compares whenever an entry is pending.
//   Instruction memory model: imem[i] = 32'h2000_0000 + i.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  typedef struct {
    logic [31:0] pcf;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [3:0]  cnt;
  } expT;

  logic clk;
  logic rst;
  logic rstB;

  logic [7:0]  imemAddrA, imemAddrB;
  logic [31:0] imemDataA, imemDataB;
  logic [31:0] pcfA, pcfB;

  int errors = 0;
  int checks = 0;
  bit bDone  = 1'b0;

  expT sbA[$];
  expT sbB[$];

  fetch_stage_if ifA ();
  fetch_stage_if ifB ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(8), .CNT_MAX(4'd15)) dutA (
    .clk       (clk),
    .rst       (rst),
    .ImemAddrF (imemAddrA),
    .ImemDataF (imemDataA),
    .PCF       (pcfA),
    .dec       (ifA)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .IMEM_AW(8), .CNT_MAX(4'd15)) dutB (
    .clk       (clk),
    .rst       (rstB),
    .ImemAddrF (imemAddrB),
    .ImemDataF (imemDataB),
    .PCF       (pcfB),
    .dec       (ifB)
  );

  assign imemDataA = 32'h2000_0000 + {24'h0, imemAddrA};
  assign imemDataB = 32'h2000_0000 + {24'h0, imemAddrB};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compare registered outputs on the falling edge.
  always @(negedge clk) begin
    expT e;
    if (sbA.size() > 0) begin
      e = sbA.pop_front();
      check("A.PCF",         pcfA,                  e.pcf);
      check("A.ImemAddrF",   {24'h0, imemAddrA},    {24'h0, e.pcf[9:2]});
      check("A.InstrD",      ifA.InstrD,            e.instr);
      check("A.PCPlus4D",    ifA.PCPlus4D,          e.pc4);
      check("A.InstrValidD", {31'h0, ifA.InstrValidD}, {31'h0, e.valid});
      check("A.cnt",         {28'h0, ifA.cnt},      {28'h0, e.cnt});
    end
    if (sbB.size() > 0) begin
      e = sbB.pop_front();
      check("B.PCF",         pcfB,                  e.pcf);
      check("B.InstrD",      ifB.InstrD,            e.instr);
      check("B.PCPlus4D",    ifB.PCPlus4D,          e.pc4);
      check("B.InstrValidD", {31'h0, ifB.InstrValidD}, {31'h0, e.valid});
      check("B.cnt",         {28'h0, ifB.cnt},      {28'h0, e.cnt});
    end
  end

  // Directly compare dutA against its reset state (used while rst is high).
  task automatic checkResetA(input string tag);
    check({tag, ".PCF"},      pcfA,                      32'h0);
    check({tag, ".InstrD"},   ifA.InstrD,                32'h0);
    check({tag, ".PCPlus4D"}, ifA.PCPlus4D,              32'h0);
    check({tag, ".valid"},    {31'h0, ifA.InstrValidD},  32'h0);
    check({tag, ".cnt"},      {28'h0, ifA.cnt},          32'h0);
  endtask

  // One clock of dutA: drive controls, push expected post-edge state.
  task automatic stepA(input logic sf, input logic sd, input logic fl,
                       input logic src, input logic [31:0] tgt,
                       input logic [31:0] pcf, input logic [31:0] instr,
                       input logic [31:0] pc4, input logic v, input logic [3:0] c);
    expT e;
    ifA.StallF    = sf;
    ifA.StallD    = sd;
    ifA.FlushD    = fl;
    ifA.PCSrcD    = src;
    ifA.PCTargetD = tgt;
    @(posedge clk);
    #1;
    e.pcf = pcf; e.instr = instr; e.pc4 = pc4; e.valid = v; e.cnt = c;
    sbA.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic pushB(input logic [31:0] pcf, input logic [31:0] instr,
                       input logic [31:0] pc4, input logic [3:0] c);
    expT e;
    e.pcf = pcf; e.instr = instr; e.pc4 = pc4; e.valid = 1'b1; e.cnt = c;
    sbB.push_back(e);
  endtask

  // Watchdog: the run is bounded well below this.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // dutB: wrap through 2^32 and counter saturation, idle controls.
  initial begin
    rstB = 1'b1;
    ifB.StallF = 1'b0; ifB.StallD = 1'b0; ifB.FlushD = 1'b0;
    ifB.PCSrcD = 1'b0; ifB.PCTargetD = 32'h0;
    #12;
    check("B.reset.PCF", pcfB,             32'hFFFF_FFF8);
    check("B.reset.cnt", {28'h0, ifB.cnt}, 32'h0);
    @(negedge clk);
    rstB = 1'b0;
    @(posedge clk); #1; pushB(32'hFFFF_FFFC, 32'h2000_00FE, 32'hFFFF_FFFC, 4'd1);
    @(posedge clk); #1; pushB(32'h0000_0000, 32'h2000_00FF, 32'h0000_0000, 4'd2);
    @(posedge clk); #1; pushB(32'h0000_0004, 32'h2000_0000, 32'h0000_0004, 4'd3);
    repeat (18) @(posedge clk);
    @(posedge clk); #1; pushB(32'h0000_0050, 32'h2000_0013, 32'h0000_0050, 4'd15);
    @(posedge clk); #1; pushB(32'h0000_0054, 32'h2000_0014, 32'h0000_0054, 4'd15);
    @(posedge clk); #1; pushB(32'h0000_0058, 32'h2000_0015, 32'h0000_0058, 4'd15);
    @(negedge clk); #1;
    bDone = 1'b1;
  end

  // dutA: main directed sequence.
  initial begin
    rst = 1'b1;
    ifA.StallF = 1'b0; ifA.StallD = 1'b0; ifA.FlushD = 1'b0;
    ifA.PCSrcD = 1'b0; ifA.PCTargetD = 32'h0;
    #12;
    checkResetA("A.reset");
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Four free-running cycles.
    stepA(0,0,0,0,32'h0,  32'h04, 32'h2000_0000, 32'h04, 1, 4'd1);
    stepA(0,0,0,0,32'h0,  32'h08, 32'h2000_0001, 32'h08, 1, 4'd2);
    stepA(0,0,0,0,32'h0,  32'h0C, 32'h2000_0002, 32'h0C, 1, 4'd3);
    stepA(0,0,0,0,32'h0,  32'h10, 32'h2000_0003, 32'h10, 1, 4'd4);
    // Redirect to misaligned 0x43 with flush: target aligned, bubble in IF/ID.
    stepA(0,0,1,1,32'h43, 32'h40, 32'h0,         32'h0,  0, 4'd5);
    stepA(0,0,0,0,32'h0,  32'h44, 32'h2000_0010, 32'h44, 1, 4'd6);
    // Redirect to 8 without flush: delay-slot instruction (imem[0x11]) kept.
    stepA(0,0,0,1,32'h08, 32'h08, 32'h2000_0011, 32'h48, 1, 4'd7);
    // Full stall for 3 edges at PCF=8.
    stepA(1,1,0,0,32'h0,  32'h08, 32'h2000_0011, 32'h48, 1, 4'd8);
    stepA(1,1,0,0,32'h0,  32'h08, 32'h2000_0011, 32'h48, 1, 4'd9);
    stepA(1,1,0,0,32'h0,  32'h08, 32'h2000_0011, 32'h48, 1, 4'd10);
    // Resume: instruction at 8 enters decode, nothing lost or repeated.
    stepA(0,0,0,0,32'h0,  32'h0C, 32'h2000_0002, 32'h0C, 1, 4'd11);
    stepA(0,0,0,0,32'h0,  32'h10, 32'h2000_0003, 32'h10, 1, 4'd12);
    // Redirect held during StallF: ignored, then taken once the stall drops.
    stepA(1,1,0,1,32'h20, 32'h10, 32'h2000_0003, 32'h10, 1, 4'd13);
    stepA(1,1,0,1,32'h20, 32'h10, 32'h2000_0003, 32'h10, 1, 4'd14);
    stepA(0,0,0,1,32'h20, 32'h20, 32'h2000_0004, 32'h14, 1, 4'd15);
    // Counter saturated at 15.
    stepA(0,0,0,0,32'h0,  32'h24, 32'h2000_0008, 32'h24, 1, 4'd15);
    stepA(0,0,0,0,32'h0,  32'h28, 32'h2000_0009, 32'h28, 1, 4'd15);

    // Reset pulse across an edge: state held at reset values.
    rst = 1'b1;
    #1;
    checkResetA("A.rst2");
    @(posedge clk); #1;
    checkResetA("A.rst2hold");
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Nine free cycles: PCF reaches 0x24 with cnt=9.
    for (int n = 1; n <= 9; n++)
      stepA(0,0,0,0,32'h0, 32'(4*n), 32'h2000_0000 + 32'(n-1), 32'(4*n), 1, 4'(n));

    // Asynchronous reset mid-cycle: outputs clear before the next edge.
    #2;
    rst = 1'b1;
    #1;
    checkResetA("A.async");
    @(posedge clk); #1;
    checkResetA("A.asynchold");
    @(negedge clk);
    rst = 1'b0;
    #1;
    stepA(0,0,0,0,32'h0, 32'h04, 32'h2000_0000, 32'h04, 1, 4'd1);
    stepA(0,0,0,0,32'h0, 32'h08, 32'h2000_0001, 32'h08, 1, 4'd2);

    // Wait (bounded) for the dutB process and the monitor to drain.
    for (int i = 0; i < 50 && !bDone; i++) @(posedge clk);
    @(negedge clk); #1;
    check("B.finished",    {31'h0, bDone},     32'h1);
    check("A.queue_empty", 32'(sbA.size()),    32'h0);
    check("B.queue_empty", 32'(sbB.size()),    32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the MIPS pipeline CPU.
- It is the producer side of the decode interface: it drives InstrD and the warm-up counter cnt that the decode-stage control unit consumes.
- It holds the PC, addresses the instruction memory and applies hazard-unit stall/flush controls.
- It applies branch/jump redirects resolved in decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0).
- IMEM_AW, 8, word-address width of the instruction memory.
- CNT_MAX, 4'd15, saturation value of the warm-up counter cnt.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- ImemAddrF  output  IMEM_AW  word address to instruction memory, equal to PCF[IMEM_AW+1:2]
- ImemDataF  input  32  instruction word returned combinationally for ImemAddrF
- StallF  input  1  hold PC
- StallD  input  1  hold IF/ID register
- FlushD  input  1  load NOP bubble into IF/ID
- PCSrcD  input  1  redirect request (taken branch / J / JR) from decode
- PCTargetD  input  32  redirect target
- PCF  output  32  current fetch PC
- InstrD  output  32  instruction presented to decode
- PCPlus4D  output  32  PC+4 of the instruction in InstrD
- InstrValidD  output  1  InstrD holds a genuinely fetched instruction
- cnt  output  4  cycles since reset, saturating; decode ignores InstrD while cnt < 2

Behaviour:
Reset:
- Asynchronous, active-high. While rst=1, and immediately on assertion mid-operation:
  - PCF=RESET_PC, InstrD=0 (NOP), PCPlus4D=0, InstrValidD=0, cnt=0.
- The first rising edge after rst falls performs normal updates.

PC register:
- PCPlus4F = PCF + 32'd4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Next PC priority:
  - StallF=1: hold PCF. Any redirect is ignored that cycle; the hazard unit keeps PCSrcD asserted until the stall is released.
  - else PCSrcD=1: PCF <= {PCTargetD[31:2],2'b00}. Target bits [1:0] are forced to 0.
  - else: PCF <= PCPlus4F.
- ImemAddrF is combinational from PCF. There is no extra fetch latency, so an instruction at PCF is in InstrD one edge later.

IF/ID register:
- Priority FlushD > StallD > load.
  - FlushD=1: InstrD<=0, PCPlus4D<=0, InstrValidD<=0. This applies even if StallD=1.
  - StallD=1: hold InstrD, PCPlus4D, InstrValidD.
  - else: InstrD<=ImemDataF, PCPlus4D<=PCPlus4F, InstrValidD<=1.
- A taken redirect does not self-flush. The hazard unit asserts FlushD together with PCSrcD when the delay-slot instruction must be squashed.

Warm-up counter cnt:
- Increments by 1 every edge after reset, independent of stalls and flushes.
- Saturates at CNT_MAX and never wraps.
- cnt >= 2 from the second edge after reset release.

Simultaneous events:
- StallF=1, StallD=0, FlushD=0: InstrD reloads the same PCF's instruction (duplicate allowed; the hazard unit never issues this combination).
- StallF=0, PCSrcD=1, FlushD=1: PCF takes the target and InstrD becomes a bubble on the same edge.

Test Plan:
- Reset release, 4 free cycles, imem[i]=32'h2000_0000+i:
  - PCF sequence 0,4,8,C,10.
  - InstrD = imem[0..3] on successive cycles, PCPlus4D = 4,8,C,10.
  - cnt = 1,2,3,4; InstrValidD=1 from the first edge.
- StallF=StallD=1 for 3 cycles at PCF=8:
  - PCF, InstrD and PCPlus4D are frozen for exactly 3 edges.
  - The sequence resumes at C with no instruction lost or duplicated.
- PCSrcD=1, PCTargetD=32'h0000_0043, FlushD=1 at PCF=10:
  - Next edge PCF=32'h40, InstrD=0, InstrValidD=0.
  - Following edge InstrD=imem[0x10].
- Redirect during StallF=1: PCF holds; the redirect is taken on the first edge after StallF drops with PCSrcD still high.
- Wrap and saturation:
  - Set RESET_PC=32'hFFFF_FFF8 and run 3 cycles: PCF goes FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - Run 20 cycles: cnt sticks at 15.
- Assert rst asynchronously mid-cycle while PCF=24 and cnt=9:
  - Outputs go to reset values before the next clock edge.
  - Fetch restarts at RESET_PC after release.
